// File: rtl/ydemux_lane_router.sv
// Registered 1-to-LANES demultiplexer with per-lane valid/ready holding registers,
// all-or-nothing broadcast, and saturating per-lane delivery counters.
module ydemux_lane_router #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned SELW = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_bcast,
  output logic [LANES-1:0]      out_valid,
  input  logic [LANES-1:0]      out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES*CNTW-1:0] lane_count
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [LANES-1:0] w_valid;
  logic [LANES-1:0] w_can;
  logic [LANES-1:0] w_load;
  logic [LANES-1:0] w_deliver;
  logic             w_accept;

  // A lane can take a word when empty or being drained this cycle.
  assign w_can    = ~w_valid | out_ready;
  assign in_ready = in_bcast ? (&w_can) : w_can[in_sel];
  assign w_accept = in_valid & in_ready;
  assign out_valid = w_valid;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNTW-1:0]  r_count;

    assign w_load[g]    = w_accept & (in_bcast | (in_sel == SELW'(g)));
    assign w_deliver[g] = r_valid & out_ready[g];

    // Reload wins over drain so a same-edge drain+reload keeps the lane full.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_load[g]) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
      end else if (w_deliver[g]) begin
        r_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= '0;
      end else if (w_deliver[g] && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNTW'(1);
      end
    end

    assign w_valid[g]                     = r_valid;
    assign out_data[g*WIDTH +: WIDTH]     = r_data;
    assign lane_count[g*CNTW +: CNTW]     = r_count;
  end

endmodule

// File: tb/tb_ydemux_lane_router.sv
// Bench for ydemux_lane_router: spec-level lane model with per-lane scoreboard queues,
// hand sequences for multi-cycle cases and a table-driven select/ready sweep.
module tb_ydemux_lane_router;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned CNTW  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [1:0]              in_sel;
  logic                    in_bcast;
  logic [LANES-1:0]        out_valid;
  logic [LANES-1:0]        out_ready;
  logic [LANES*WIDTH-1:0]  out_data;
  logic [LANES*CNTW-1:0]   lane_count;

  ydemux_lane_router #(.WIDTH(WIDTH), .LANES(LANES), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lane_count(lane_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [LANES-1:0] m_valid;
  logic [WIDTH-1:0] m_data  [LANES];
  logic [CNTW-1:0]  m_count [LANES];
  logic [WIDTH-1:0] sb_q    [LANES][$];

  typedef struct {
    logic [1:0] sel;
    logic [3:0] rdy;
    logic       exp_rdy;
  } vec_t;
  vec_t vecs [64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      m_data[i]  = '0;
      m_count[i] = '0;
      sb_q[i].delete();
    end
  endtask

  // One clock: check in_ready and deliveries before the edge, state after it.
  task automatic cyc();
    logic [3:0]       can;
    logic             exp_rdy;
    logic             acc;
    logic [WIDTH-1:0] w;
    #1;
    can     = ~m_valid | out_ready;
    exp_rdy = in_bcast ? (&can) : can[in_sel];
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    for (int i = 0; i < LANES; i++) begin
      if (m_valid[i] && out_ready[i]) begin
        if (sb_q[i].size() == 0) begin
          chk($sformatf("sb_underflow_lane%0d", i), 64'(1), 64'(0));
        end else begin
          w = sb_q[i].pop_front();
          chk($sformatf("deliver_lane%0d", i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(w));
        end
        if (m_count[i] != 8'hFF) m_count[i] = m_count[i] + 8'd1;
        m_valid[i] = 1'b0;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      if (acc && (in_bcast || in_sel == 2'(i))) begin
        m_valid[i] = 1'b1;
        m_data[i]  = in_data;
        sb_q[i].push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("out_data_lane%0d", i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(m_data[i]));
      chk($sformatf("lane_count%0d", i), 64'(lane_count[i*CNTW +: CNTW]), 64'(m_count[i]));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b,
                       input logic [WIDTH-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(0));
      chk($sformatf("%s_count%0d", tag, i), 64'(lane_count[i*CNTW +: CNTW]), 64'(0));
    end
  endtask

  initial begin
    int err_before;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, '0, 4'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state("por");
    chk("por_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // Unicast into an idle consumer: load, hold, block, other lane proceeds.
    drive(1'b1, 2'd2, 1'b0, 32'hA5A5_0001, 4'h0);
    cyc();
    chk("uni_valid_after_load", 64'(out_valid), 64'(4'b0100));
    drive(1'b0, 2'd2, 1'b0, 32'h0, 4'h0);
    cyc();
    cyc();
    chk("uni_hold_data", 64'(out_data[2*WIDTH +: WIDTH]), 64'(32'hA5A5_0001));
    drive(1'b1, 2'd2, 1'b0, 32'hA5A5_0002, 4'h0);
    #1;
    chk("uni_lane2_blocked", 64'(in_ready), 64'(0));
    cyc();
    drive(1'b1, 2'd1, 1'b0, 32'hA5A5_0003, 4'h0);
    #1;
    chk("uni_lane1_ready", 64'(in_ready), 64'(1));
    cyc();
    chk("uni_two_lanes", 64'(out_valid), 64'(4'b0110));
    drive(1'b0, 2'd0, 1'b0, 32'h0, 4'hF);
    cyc();
    chk("uni_drained", 64'(out_valid), 64'(0));

    // Streaming on lane 0 with consumer always ready.
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 2'd0, 1'b0, WIDTH'(k), 4'b0001);
      cyc();
      chk("stream_word", 64'(out_data[0 +: WIDTH]), 64'(k));
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0001);
    cyc();
    chk("stream_count", 64'(lane_count[0 +: CNTW]), 64'(10));
    chk("stream_valid_drop", 64'(out_valid[0]), 64'(0));

    // Broadcast blocked by a full lane 3, then released.
    drive(1'b1, 2'd3, 1'b0, 32'h3333_3333, 4'h0);
    cyc();
    drive(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF, 4'h0);
    #1;
    chk("bcast_blocked", 64'(in_ready), 64'(0));
    cyc();
    chk("bcast_no_change", 64'(out_valid), 64'(4'b1000));
    drive(1'b1, 2'd0, 1'b1, 32'hDEAD_BEEF, 4'b1000);
    cyc();
    chk("bcast_all_valid", 64'(out_valid), 64'(4'b1111));
    for (int i = 0; i < LANES; i++)
      chk($sformatf("bcast_data%0d", i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(32'hDEAD_BEEF));
    drive(1'b0, 2'd0, 1'b0, 32'h0, 4'hF);
    cyc();

    // Reset asserted mid-traffic with lane 2 full.
    drive(1'b1, 2'd2, 1'b0, 32'h2222_0002, 4'h0);
    cyc();
    chk("pre_reset_lane2", 64'(out_valid), 64'(4'b0100));
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    check_reset_state("rst_async");
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    chk("rst_in_ready_held", 64'(in_ready), 64'(1));
    model_reset();
    rst_n = 1'b1;

    // Counter saturation on lane 1.
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 2'd1, 1'b0, $urandom, 4'b0010);
      cyc();
    end
    drive(1'b0, 2'd1, 1'b0, 32'h0, 4'b0010);
    cyc();
    chk("sat_lane1", 64'(lane_count[1*CNTW +: CNTW]), 64'(255));
    chk("sat_lane0", 64'(lane_count[0 +: CNTW]), 64'(0));
    chk("sat_lane2", 64'(lane_count[2*CNTW +: CNTW]), 64'(0));
    chk("sat_lane3", 64'(lane_count[3*CNTW +: CNTW]), 64'(0));

    // Select x ready sweep with lanes 1 and 3 full, lanes 0 and 2 empty.
    for (int s = 0; s < 4; s++) begin
      for (int r = 0; r < 16; r++) begin
        logic [3:0] rv;
        rv = 4'(r);
        vecs[s*16+r].sel     = 2'(s);
        vecs[s*16+r].rdy     = rv;
        vecs[s*16+r].exp_rdy = (s == 0 || s == 2) ? 1'b1 : rv[s];
      end
    end
    for (int v = 0; v < 64; v++) begin
      drive(1'b0, 2'd0, 1'b0, 32'h0, 4'hF);
      cyc();
      drive(1'b1, 2'd1, 1'b0, $urandom, 4'h0);
      cyc();
      drive(1'b1, 2'd3, 1'b0, $urandom, 4'h0);
      cyc();
      err_before = n_err;
      drive(1'b1, vecs[v].sel, 1'b0, $urandom, vecs[v].rdy);
      #1;
      chk($sformatf("sweep_ready_v%0d", v), 64'(in_ready), 64'(vecs[v].exp_rdy));
      cyc();
      if (n_err == err_before)
        $display("vector %0d sel=%0d rdy=%b PASS", v, vecs[v].sel, vecs[v].rdy);
    end
    drive(1'b0, 2'd0, 1'b0, 32'h0, 4'hF);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ydemux_lane_router.md
Name: ydemux_lane_router

Overview:
- Registered 1-to-LANES demultiplexer: the distributing counterpart of the yMux selector family.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it into the holding register of the selected output lane, or of all lanes in broadcast mode.
- Each lane presents its word on its own valid/ready output and keeps a saturating count of delivered words.
- Sits between a single producer (datapath result bus) and several consumers (per-unit input ports).

Parameters:
- WIDTH, 32, data word width in bits.
- LANES, 4, number of output lanes; must be a power of 2, minimum 2.
- SELW, log2(LANES) = 2, lane-select width; derived, not overridden.
- CNTW, 8, width of each per-lane delivered counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers a word this cycle.
- in_ready  output  1  router accepts a word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  SELW  target lane index; ignored when in_bcast=1.
- in_bcast  input  1  route the word to every lane.
- out_valid  output  LANES  bit i: lane i holds a word.
- out_ready  input  LANES  bit i: consumer i takes the lane-i word.
- out_data  output  LANES*WIDTH  lane i word at bits [i*WIDTH +: WIDTH].
- lane_count  output  LANES*CNTW  lane i delivered count at bits [i*CNTW +: CNTW].

Behaviour:
- Reset (async assert, sync release): out_valid=0, every out_data lane=0, every lane_count lane=0. in_ready follows the combinational rule below, so it reads 1 during reset.
- Reset asserted mid-operation discards held words immediately; no partial deliveries are counted.
- Lane i can accept a word when its holding register is empty or draining: can_i = !out_valid[i] || out_ready[i]. This is a combinational ready path.
- in_ready:
  - in_bcast=0: in_ready = can[in_sel].
  - in_bcast=1: in_ready = AND of can over all lanes. Broadcast is all-or-nothing; no lane is written unless every lane can accept.
- Accept: a word is accepted when in_valid && in_ready at the clock edge.
  - Unicast: lane in_sel loads in_data and sets out_valid=1.
  - Broadcast: every lane loads in_data and sets out_valid=1.
- Latency: a word accepted at edge N is visible on out_data/out_valid immediately after edge N, so the consumer can take it at edge N+1. Throughput is 1 word/cycle per lane.
- Hold: while out_valid[i]=1 && out_ready[i]=0, lane i data and valid are stable. Input for another lane is unaffected.
- Drain: out_valid[i] && out_ready[i] at an edge is a delivery.
  - out_valid[i] clears, unless the same edge reloads lane i.
  - out_data[i] keeps its last value after the drain.
- Simultaneous drain and reload of the same lane: the new word is loaded, out_valid stays 1, and the delivery still counts.
- Counters: lane_count[i] increments by 1 per delivery and saturates at 2^CNTW-1 (255); it never wraps.
- in_valid=0 with any in_sel/in_bcast/in_data: no state change.
- Input signals must be stable while in_valid && !in_ready. The router does not check this.
- out_ready on an empty lane has no effect.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with lane 2 full -> out_valid=4'b0000, lane_count all 0, in_ready=1 while rst_n=0.
- Unicast, consumer idle: in_data=32'hA5A5_0001, in_sel=2, out_ready=0 for 3 cycles -> out_valid=4'b0100 after one edge, data held stable. Second offer to lane 2 sees in_ready=0. An offer to lane 1 in the same cycle is accepted.
- Streaming: lane 0, out_ready[0]=1 held, 10 back-to-back words 1..10 -> in_ready stays 1, each word appears one cycle after acceptance, lane_count[0]=10, out_valid[0] drops after the last word.
- Broadcast blocking: lane 3 full with out_ready[3]=0, in_bcast=1, data 32'hDEAD_BEEF -> in_ready=0 and no lane changes. Raise out_ready[3] -> accepted, out_valid=4'b1111, all lanes read DEAD_BEEF.
- Counter saturation: 300 deliveries on lane 1 -> lane_count[1]=255, other lanes 0.
- Exhaustive select sweep: every in_sel 0..3 x out_ready patterns 0..15 -> in_ready matches the can_i rule, and out_data lanes match a reference model every cycle, with PASS/FAIL printed per vector.
